mem_req_initiator: RTL and testbench

Request-initiator counterpart of the DPI RAM simulator model. It accepts read/write commands from an upstream traffic source and drives the simulator's `rvalid`/`raddr`, `wvalid`/`waddr`/`wdata` request interface, honouring `readReady`/`writeReady`. It tracks outstanding transactions per direction and pairs each `readfin` with its issued address to return tagged read responses upstream. It sits between testbench traffic generators or CPU-side models and the RAM model.

---
 rtl/mem_req_initiator.sv | 170 +++++++++++++++++
 tb/tb_mem_req_initiator.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_initiator.sv
// Request initiator for the DPI RAM model: a single-entry request stage feeding the
// read/write request ports, per-direction credit counters and an in-order read tag FIFO.
module mem_req_initiator #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [AW-1:0]                    cmd_addr,
    input  logic [DW-1:0]                    cmd_wdata,
    output logic                             rvalid,
    output logic [AW-1:0]                    raddr,
    input  logic                             readReady,
    output logic                             wvalid,
    output logic [AW-1:0]                    waddr,
    output logic [DW-1:0]                    wdata,
    input  logic                             writeReady,
    input  logic                             readfin,
    input  logic [DW-1:0]                    rdata,
    input  logic                             writefin,
    output logic                             rsp_valid,
    output logic [AW-1:0]                    rsp_addr,
    output logic [DW-1:0]                    rsp_data,
    output logic [$clog2(MAX_OUTSTANDING):0] rd_outstanding,
    output logic [$clog2(MAX_OUTSTANDING):0] wr_outstanding,
    output logic                             busy,
    output logic                             err_unexpected
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUTSTANDING);

    logic          pend_q, pend_d;
    logic          reqWrite_q, reqWrite_d;
    logic [AW-1:0] reqAddr_q, reqAddr_d;
    logic [DW-1:0] reqData_q, reqData_d;

    logic [AW-1:0] raddrHold_q;
    logic [AW-1:0] waddrHold_q;
    logic [DW-1:0] wdataHold_q;

    logic [CW-1:0] rdCnt_q, rdCnt_d;
    logic [CW-1:0] wrCnt_q, wrCnt_d;

    logic [AW-1:0] tagMem_q [MAX_OUTSTANDING];
    logic [PW-1:0] tagWrPtr_q;
    logic [PW-1:0] tagRdPtr_q;

    logic          rspValid_q;
    logic [AW-1:0] rspAddr_q;
    logic [DW-1:0] rspData_q;
    logic          err_q;

    logic pendRd, pendWr;
    logic hsRd, hsWr;
    logic accept;
    logic popRd, popWr;
    logic finErr;

    assign pendRd = pend_q & ~reqWrite_q;
    assign pendWr = pend_q & reqWrite_q;

    assign rvalid = pendRd & (rdCnt_q < MaxCnt);
    assign wvalid = pendWr & (wrCnt_q < MaxCnt);
    assign hsRd   = rvalid & readReady;
    assign hsWr   = wvalid & writeReady;

    assign cmd_ready = ~pend_q | hsRd | hsWr;
    assign accept    = cmd_valid & cmd_ready;

    // A fin with nothing outstanding is flagged instead of underflowing the counter.
    assign popRd  = readfin & (rdCnt_q != '0);
    assign popWr  = writefin & (wrCnt_q != '0);
    assign finErr = (readfin & ~popRd) | (writefin & ~popWr);

    // The RAM derives ready from the address, so it is shown even while valid is held off.
    assign raddr = pendRd ? reqAddr_q : raddrHold_q;
    assign waddr = pendWr ? reqAddr_q : waddrHold_q;
    assign wdata = pendWr ? reqData_q : wdataHold_q;

    assign rsp_valid      = rspValid_q;
    assign rsp_addr       = rspAddr_q;
    assign rsp_data       = rspData_q;
    assign rd_outstanding = rdCnt_q;
    assign wr_outstanding = wrCnt_q;
    assign busy           = pend_q | (rdCnt_q != '0) | (wrCnt_q != '0);
    assign err_unexpected = err_q;

    always_comb begin
        pend_d     = pend_q;
        reqWrite_d = reqWrite_q;
        reqAddr_d  = reqAddr_q;
        reqData_d  = reqData_q;
        if (accept) begin
            pend_d     = 1'b1;
            reqWrite_d = cmd_write;
            reqAddr_d  = cmd_addr;
            reqData_d  = cmd_wdata;
        end else if (hsRd | hsWr) begin
            pend_d = 1'b0;
        end
        rdCnt_d = rdCnt_q + {{(CW-1){1'b0}}, hsRd} - {{(CW-1){1'b0}}, popRd};
        wrCnt_d = wrCnt_q + {{(CW-1){1'b0}}, hsWr} - {{(CW-1){1'b0}}, popWr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            reqWrite_q  <= 1'b0;
            reqAddr_q   <= '0;
            reqData_q   <= '0;
            raddrHold_q <= '0;
            waddrHold_q <= '0;
            wdataHold_q <= '0;
            rdCnt_q     <= '0;
            wrCnt_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            reqWrite_q <= reqWrite_d;
            reqAddr_q  <= reqAddr_d;
            reqData_q  <= reqData_d;
            rdCnt_q    <= rdCnt_d;
            wrCnt_q    <= wrCnt_d;
            if (pendRd) begin
                raddrHold_q <= reqAddr_q;
            end
            if (pendWr) begin
                waddrHold_q <= reqAddr_q;
                wdataHold_q <= reqData_q;
            end
            if (finErr) begin
                err_q <= 1'b1;
            end
        end
    end

    // Occupancy of the tag FIFO always equals rdCnt_q, so credit gating keeps it from overflowing.
    always_ff @(posedge clk) begin
        if (hsRd) begin
            tagMem_q[tagWrPtr_q] <= reqAddr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tagWrPtr_q <= '0;
            tagRdPtr_q <= '0;
            rspValid_q <= 1'b0;
            rspAddr_q  <= '0;
            rspData_q  <= '0;
        end else begin
            rspValid_q <= popRd;
            if (hsRd) begin
                tagWrPtr_q <= tagWrPtr_q + 1'b1;
            end
            if (popRd) begin
                tagRdPtr_q <= tagRdPtr_q + 1'b1;
                rspAddr_q  <= tagMem_q[tagRdPtr_q];
                rspData_q  <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Bench for mem_req_initiator: a hand-derived vector table, directed corner sequences,
// then random traffic compared every cycle against a queue-based reference model.
module tb_mem_req_initiator;

    localparam int MAXO = 4;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int CW   = $clog2(MAXO) + 1;

    typedef struct {
        logic          cv;
        logic          cw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          rr;
        logic          wr;
        logic          rf;
        logic [DW-1:0] rd;
        logic          wf;
    } stim_t;

    typedef struct {
        stim_t         s;
        logic          expCmdReady;
        logic          expRvalid;
        logic [AW-1:0] expRaddr;
        int            expRdOut;
        logic          expRspValid;
        logic [AW-1:0] expRspAddr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rvalid, readReady;
    logic [AW-1:0] raddr;
    logic          wvalid, writeReady;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          readfin, writefin;
    logic [DW-1:0] rdata;
    logic          rsp_valid;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic [CW-1:0] rd_outstanding, wr_outstanding;
    logic          busy, err_unexpected;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: issued reads live in a queue whose size is the read credit in use.
    bit            mPend, mWrite;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mData;
    logic [AW-1:0] tagQ[$];
    int            mWrCnt;
    bit            mErr;
    bit            mRspValid;
    logic [AW-1:0] mRspAddr;
    logic [DW-1:0] mRspData;
    logic [AW-1:0] mRaddr, mWaddr;
    logic [DW-1:0] mWdata;

    int            hsRdSeen, hsWrSeen, rvalidCycles;
    logic [AW-1:0] rspAddrSeen[$];
    logic [DW-1:0] rspDataSeen[$];

    always #5 clk = ~clk;

    mem_req_initiator #(.MAX_OUTSTANDING(MAXO), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rvalid(rvalid), .raddr(raddr), .readReady(readReady),
        .wvalid(wvalid), .waddr(waddr), .wdata(wdata), .writeReady(writeReady),
        .readfin(readfin), .rdata(rdata), .writefin(writefin),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .busy(busy), .err_unexpected(err_unexpected)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stim_t mk(logic cv, logic cw, logic [AW-1:0] addr, logic [DW-1:0] wd,
                                 logic rr, logic wr, logic rf, logic [DW-1:0] rd, logic wf);
        stim_t s;
        s.cv = cv; s.cw = cw; s.addr = addr; s.wd = wd;
        s.rr = rr; s.wr = wr; s.rf = rf; s.rd = rd; s.wf = wf;
        return s;
    endfunction

    function automatic stim_t idle(logic rr, logic wr);
        return mk(1'b0, 1'b0, 64'h0, 64'h0, rr, wr, 1'b0, 64'h0, 1'b0);
    endfunction

    function automatic vec_t vec(stim_t s, logic cr, logic rv, logic [AW-1:0] ra, int ro,
                                 logic rsv, logic [AW-1:0] rsa);
        vec_t v;
        v.s = s; v.expCmdReady = cr; v.expRvalid = rv; v.expRaddr = ra;
        v.expRdOut = ro; v.expRspValid = rsv; v.expRspAddr = rsa;
        return v;
    endfunction

    task automatic expect64(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectBit(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mPend = 0; mWrite = 0; mAddr = '0; mData = '0;
        tagQ.delete();
        mWrCnt = 0; mErr = 0;
        mRspValid = 0; mRspAddr = '0; mRspData = '0;
        mRaddr = '0; mWaddr = '0; mWdata = '0;
    endtask

    task automatic clearObs();
        hsRdSeen = 0; hsWrSeen = 0; rvalidCycles = 0;
        rspAddrSeen.delete();
        rspDataSeen.delete();
    endtask

    task automatic driveInputs(input stim_t s);
        cmd_valid = s.cv; cmd_write = s.cw; cmd_addr = s.addr; cmd_wdata = s.wd;
        readReady = s.rr; writeReady = s.wr;
        readfin = s.rf; rdata = s.rd; writefin = s.wf;
    endtask

    // Compares every output against the model for the inputs currently applied.
    task automatic checkOutput();
        bit eRv, eWv, eHsR, eHsW;
        eRv  = mPend && !mWrite && (tagQ.size() < MAXO);
        eWv  = mPend && mWrite && (mWrCnt < MAXO);
        eHsR = eRv && readReady;
        eHsW = eWv && writeReady;
        expectBit("cmd_ready", cmd_ready, !mPend || eHsR || eHsW);
        expectBit("rvalid", rvalid, eRv);
        expectBit("wvalid", wvalid, eWv);
        expect64("raddr", raddr, (mPend && !mWrite) ? mAddr : mRaddr);
        expect64("waddr", waddr, (mPend && mWrite) ? mAddr : mWaddr);
        expect64("wdata", wdata, (mPend && mWrite) ? mData : mWdata);
        expectBit("rsp_valid", rsp_valid, mRspValid);
        if (mRspValid) begin
            expect64("rsp_addr", rsp_addr, mRspAddr);
            expect64("rsp_data", rsp_data, mRspData);
        end
        expect64("rd_outstanding", 64'(rd_outstanding), 64'(tagQ.size()));
        expect64("wr_outstanding", 64'(wr_outstanding), 64'(mWrCnt));
        expectBit("busy", busy, mPend || (tagQ.size() != 0) || (mWrCnt != 0));
        expectBit("err_unexpected", err_unexpected, mErr);
        if (rvalid === 1'b1) rvalidCycles++;
        if (rvalid === 1'b1 && readReady) hsRdSeen++;
        if (wvalid === 1'b1 && writeReady) hsWrSeen++;
        if (rsp_valid === 1'b1) begin
            rspAddrSeen.push_back(rsp_addr);
            rspDataSeen.push_back(rsp_data);
        end
    endtask

    task automatic modelStep();
        bit eHsR, eHsW, eReady;
        eHsR   = mPend && !mWrite && (tagQ.size() < MAXO) && readReady;
        eHsW   = mPend && mWrite && (mWrCnt < MAXO) && writeReady;
        eReady = !mPend || eHsR || eHsW;
        mRspValid = 0;
        if (readfin) begin
            if (tagQ.size() == 0) mErr = 1;
            else begin
                mRspAddr  = tagQ.pop_front();
                mRspData  = rdata;
                mRspValid = 1;
            end
        end
        if (writefin) begin
            if (mWrCnt == 0) mErr = 1;
            else mWrCnt--;
        end
        if (eHsR) tagQ.push_back(mAddr);
        if (eHsW) mWrCnt++;
        if (mPend && !mWrite) mRaddr = mAddr;
        if (mPend && mWrite) begin
            mWaddr = mAddr;
            mWdata = mData;
        end
        if (cmd_valid && eReady) begin
            mPend = 1; mWrite = cmd_write; mAddr = cmd_addr; mData = cmd_wdata;
        end else if (eHsR || eHsW) begin
            mPend = 0;
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        driveInputs(s);
        #1;
        checkOutput();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        expectBit({tag, " cmd_ready"}, cmd_ready, 1'b1);
        expectBit({tag, " rvalid"}, rvalid, 1'b0);
        expectBit({tag, " wvalid"}, wvalid, 1'b0);
        expect64({tag, " raddr"}, raddr, 64'h0);
        expect64({tag, " waddr"}, waddr, 64'h0);
        expect64({tag, " wdata"}, wdata, 64'h0);
        expectBit({tag, " rsp_valid"}, rsp_valid, 1'b0);
        expect64({tag, " rsp_addr"}, rsp_addr, 64'h0);
        expect64({tag, " rsp_data"}, rsp_data, 64'h0);
        expect64({tag, " rd_outstanding"}, 64'(rd_outstanding), 64'h0);
        expect64({tag, " wr_outstanding"}, 64'(wr_outstanding), 64'h0);
        expectBit({tag, " busy"}, busy, 1'b0);
        expectBit({tag, " err_unexpected"}, err_unexpected, 1'b0);
    endtask

    // Entered just after a rising edge, so the reset lands mid-cycle.
    task automatic doReset(input string tag);
        #2;
        rst_n = 1'b0;
        driveInputs(idle(1'b0, 1'b0));
        #1;
        modelReset();
        checkResetOutputs(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clearObs();
    endtask

    initial begin
        vec_t          vecs [13];
        logic [AW-1:0] expA [3];
        logic [DW-1:0] expD [3];
        logic          rfR, wfR;

        // Credit-limit walk with readReady held high: four issue, the fifth waits for a fin.
        vecs[0]  = vec(mk(1'b1, 1'b0, 64'h100, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0), 1'b1, 1'b0, 64'h0,   0, 1'b0, 64'h0);
        vecs[1]  = vec(mk(1'b1, 1'b0, 64'h200, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0), 1'b1, 1'b1, 64'h100, 0, 1'b0, 64'h0);
        vecs[2]  = vec(mk(1'b1, 1'b0, 64'h300, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0), 1'b1, 1'b1, 64'h200, 1, 1'b0, 64'h0);
        vecs[3]  = vec(mk(1'b1, 1'b0, 64'h400, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0), 1'b1, 1'b1, 64'h300, 2, 1'b0, 64'h0);
        vecs[4]  = vec(mk(1'b1, 1'b0, 64'h500, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0), 1'b1, 1'b1, 64'h400, 3, 1'b0, 64'h0);
        vecs[5]  = vec(mk(1'b1, 1'b0, 64'h600, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0), 1'b0, 1'b0, 64'h500, 4, 1'b0, 64'h0);
        vecs[6]  = vec(mk(1'b1, 1'b0, 64'h600, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0), 1'b0, 1'b0, 64'h500, 4, 1'b0, 64'h0);
        vecs[7]  = vec(mk(1'b1, 1'b0, 64'h600, 64'h0, 1'b1, 1'b0, 1'b1, 64'hA1, 1'b0), 1'b0, 1'b0, 64'h500, 4, 1'b0, 64'h0);
        vecs[8]  = vec(mk(1'b1, 1'b0, 64'h600, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0), 1'b1, 1'b1, 64'h500, 3, 1'b1, 64'h100);
        vecs[9]  = vec(mk(1'b0, 1'b0, 64'h0,   64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0), 1'b0, 1'b0, 64'h600, 4, 1'b0, 64'h0);
        vecs[10] = vec(mk(1'b0, 1'b0, 64'h0,   64'h0, 1'b1, 1'b0, 1'b1, 64'hA2, 1'b0), 1'b0, 1'b0, 64'h600, 4, 1'b0, 64'h0);
        vecs[11] = vec(mk(1'b0, 1'b0, 64'h0,   64'h0, 1'b1, 1'b0, 1'b1, 64'hA3, 1'b0), 1'b1, 1'b1, 64'h600, 3, 1'b1, 64'h200);
        vecs[12] = vec(mk(1'b0, 1'b0, 64'h0,   64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0), 1'b1, 1'b0, 64'h600, 3, 1'b1, 64'h300);

        rst_n = 1'b0;
        driveInputs(idle(1'b0, 1'b0));
        modelReset();
        clearObs();
        #12;
        checkResetOutputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] vector table: credit limit and tagging");
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            driveInputs(vecs[i].s);
            #1;
            expectBit($sformatf("vec%0d cmd_ready", i), cmd_ready, vecs[i].expCmdReady);
            expectBit($sformatf("vec%0d rvalid", i), rvalid, vecs[i].expRvalid);
            expect64($sformatf("vec%0d raddr", i), raddr, vecs[i].expRaddr);
            expect64($sformatf("vec%0d rd_outstanding", i), 64'(rd_outstanding), 64'(vecs[i].expRdOut));
            expectBit($sformatf("vec%0d rsp_valid", i), rsp_valid, vecs[i].expRspValid);
            if (vecs[i].expRspValid) begin
                expect64($sformatf("vec%0d rsp_addr", i), rsp_addr, vecs[i].expRspAddr);
            end
            checkOutput();
            modelStep();
            @(posedge clk);
            #1;
        end

        $display("[TB] single read");
        doReset("rst1");
        applyStimulus(mk(1'b1, 1'b0, 64'h1000, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0));
        applyStimulus(idle(1'b1, 1'b0));
        expect64("single rd_outstanding after issue", 64'(rd_outstanding), 64'h1);
        repeat (19) applyStimulus(idle(1'b1, 1'b0));
        applyStimulus(mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1, 64'hDEADBEEF, 1'b0));
        applyStimulus(idle(1'b1, 1'b0));
        applyStimulus(idle(1'b1, 1'b0));
        expect64("single read handshakes", 64'(hsRdSeen), 64'h1);
        expect64("single rvalid cycles", 64'(rvalidCycles), 64'h1);
        expect64("single rsp count", 64'(rspAddrSeen.size()), 64'h1);
        if (rspAddrSeen.size() > 0) begin
            expect64("single rsp_addr", rspAddrSeen[0], 64'h1000);
            expect64("single rsp_data", rspDataSeen[0], 64'hDEADBEEF);
        end
        expect64("single rd_outstanding end", 64'(rd_outstanding), 64'h0);

        $display("[TB] write ready stall");
        doReset("rst2");
        applyStimulus(mk(1'b1, 1'b1, 64'h2000, 64'h55, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(idle(1'b0, 1'b0));
            expectBit($sformatf("stall%0d wvalid", i), wvalid, 1'b1);
            expect64($sformatf("stall%0d waddr", i), waddr, 64'h2000);
            expect64($sformatf("stall%0d wdata", i), wdata, 64'h55);
        end
        applyStimulus(idle(1'b0, 1'b1));
        applyStimulus(idle(1'b0, 1'b1));
        applyStimulus(idle(1'b0, 1'b1));
        expect64("stall write handshakes", 64'(hsWrSeen), 64'h1);
        expect64("stall wr_outstanding", 64'(wr_outstanding), 64'h1);
        expectBit("stall busy", busy, 1'b1);
        applyStimulus(mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1));
        expect64("stall wr_outstanding after fin", 64'(wr_outstanding), 64'h0);
        expectBit("stall busy after fin", busy, 1'b0);

        $display("[TB] in-order tagging");
        doReset("rst3");
        applyStimulus(mk(1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0));
        applyStimulus(mk(1'b1, 1'b0, 64'h20, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0));
        applyStimulus(mk(1'b1, 1'b0, 64'h30, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0));
        applyStimulus(idle(1'b1, 1'b0));
        applyStimulus(mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h111, 1'b0));
        applyStimulus(mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h222, 1'b0));
        applyStimulus(mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h333, 1'b0));
        applyStimulus(idle(1'b1, 1'b0));
        applyStimulus(idle(1'b1, 1'b0));
        expA[0] = 64'h10;  expA[1] = 64'h20;  expA[2] = 64'h30;
        expD[0] = 64'h111; expD[1] = 64'h222; expD[2] = 64'h333;
        expect64("order rsp count", 64'(rspAddrSeen.size()), 64'h3);
        for (int i = 0; i < 3; i++) begin
            if (i < rspAddrSeen.size()) begin
                expect64($sformatf("order rsp_addr%0d", i), rspAddrSeen[i], expA[i]);
                expect64($sformatf("order rsp_data%0d", i), rspDataSeen[i], expD[i]);
            end
        end

        $display("[TB] unexpected fin");
        doReset("rst4");
        applyStimulus(mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1));
        expectBit("unexp err set", err_unexpected, 1'b1);
        expect64("unexp wr_outstanding", 64'(wr_outstanding), 64'h0);
        expectBit("unexp rsp_valid", rsp_valid, 1'b0);
        repeat (3) applyStimulus(idle(1'b0, 1'b0));
        expectBit("unexp err sticky", err_unexpected, 1'b1);
        expect64("unexp rsp count", 64'(rspAddrSeen.size()), 64'h0);

        $display("[TB] reset mid-operation");
        doReset("rst5");
        applyStimulus(mk(1'b1, 1'b0, 64'h40, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0));
        applyStimulus(mk(1'b1, 1'b0, 64'h50, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0));
        applyStimulus(mk(1'b1, 1'b1, 64'h60, 64'h77, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0));
        applyStimulus(idle(1'b0, 1'b0));
        expect64("midrst rd_outstanding before", 64'(rd_outstanding), 64'h2);
        expectBit("midrst wvalid before", wvalid, 1'b1);
        doReset("midrst");
        applyStimulus(idle(1'b0, 1'b0));
        expectBit("midrst cmd_ready after", cmd_ready, 1'b1);
        expectBit("midrst busy after", busy, 1'b0);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) doReset("rndrst");
            rfR = (tagQ.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
            wfR = (mWrCnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
            applyStimulus(mk(logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 1)),
                             {$urandom, $urandom}, {$urandom, $urandom},
                             logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
                             rfR, {$urandom, $urandom}, wfR));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
